bitrev_reorder_ctrl: RTL and testbench

BITREV_REORDER_CTRL -- requirements
Module: bitrev_reorder_ctrl

---
 rtl/ntt_pkg.sv | 26 ++
 rtl/coef_regfile.sv | 35 +++
 rtl/bitrev_reorder_ctrl.sv | 108 ++++++++++
 tb/tb_bitrev_reorder_ctrl.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg
//   Shared definitions for the coefficient reorder path: default coefficient
//   width, frame length and index width, the controller state encoding, and
//   the bit-reversed index function.
package ntt_pkg;

    localparam int NTT_W     = 9;
    localparam int NTT_D     = 8;
    localparam int NTT_LOG_D = 3;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Reverses the low nbits of idx; upper bits of the result are zero.
    function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
        int unsigned res;
        res = 0;
        for (int unsigned i = 0; i < nbits; i++) begin
            res = (res << 1) | ((idx >> i) & 32'd1);
        end
        return res;
    endfunction

endpackage

// File: rtl/coef_regfile.sv
// coef_regfile
//   D x W coefficient storage with one synchronous write port and one
//   combinational read port. Contents are not reset.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write slot
//   i_wdata : write coefficient
//   i_raddr : read slot
//   o_rdata : coefficient at i_raddr
module coef_regfile
    import ntt_pkg::*;
#(
    parameter int W     = NTT_W,
    parameter int D     = NTT_D,
    parameter int LOG_D = NTT_LOG_D
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [LOG_D-1:0] i_waddr,
    input  logic [W-1:0]     i_wdata,
    input  logic [LOG_D-1:0] i_raddr,
    output logic [W-1:0]     o_rdata
);

    logic [W-1:0] r_mem [D];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bitrev_reorder_ctrl.sv
// bitrev_reorder_ctrl
//   Collects a frame of D coefficients in natural order, then replays it in
//   bit-reversed index order. Loading and draining alternate strictly.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (discards any partial frame)
//   in_valid   : input coefficient present
//   in_ready   : high while loading
//   in_data    : input coefficient, natural order
//   out_valid  : high while draining
//   out_ready  : downstream accepts output
//   out_data   : output coefficient, bit-reversed order
//   out_last   : final coefficient of the frame
//   busy       : high unless idle in LOAD with nothing collected
//   frame_done : one-cycle pulse after the final output transfer
module bitrev_reorder_ctrl
    import ntt_pkg::*;
#(
    parameter int W     = NTT_W,
    parameter int D     = NTT_D,
    parameter int LOG_D = NTT_LOG_D
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy,
    output logic         frame_done
);

    localparam logic [LOG_D-1:0] LAST_IDX = LOG_D'(D - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [LOG_D-1:0] r_wr_cnt;
    logic [LOG_D-1:0] r_rd_cnt;
    logic [LOG_D-1:0] w_rd_addr;
    logic             r_frame_done;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_wr_last;
    logic             w_rd_last;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign w_wr_last  = (r_wr_cnt == LAST_IDX);
    assign w_rd_last  = (r_rd_cnt == LAST_IDX);
    assign w_rd_addr  = LOG_D'(bitrev(32'(r_rd_cnt), LOG_D));

    // State register and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_LOAD;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_out_xfer && w_rd_last;
            if (w_in_xfer) begin
                r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + 1'b1;
            end
            if (w_out_xfer) begin
                r_rd_cnt <= w_rd_last ? '0 : r_rd_cnt + 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD:  if (w_in_xfer && w_wr_last)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_out_xfer && w_rd_last) w_state_nxt = ST_LOAD;
            default:  w_state_nxt = ST_LOAD;
        endcase
    end

    // Outputs depend only on state and counters, so data and last stay
    // stable across output stalls.
    always_comb begin
        in_ready  = (r_state == ST_LOAD);
        out_valid = (r_state == ST_DRAIN);
        out_last  = (r_state == ST_DRAIN) && w_rd_last;
        busy      = !((r_state == ST_LOAD) && (r_wr_cnt == '0));
    end

    assign frame_done = r_frame_done;

    // Writes only happen on input transfers, which cannot occur in DRAIN.
    coef_regfile #(
        .W     (W),
        .D     (D),
        .LOG_D (LOG_D)
    ) u_regfile (
        .i_clk   (clk),
        .i_we    (w_in_xfer),
        .i_waddr (r_wr_cnt),
        .i_wdata (in_data),
        .i_raddr (w_rd_addr),
        .o_rdata (out_data)
    );

endmodule

// File: tb/tb_bitrev_reorder_ctrl.sv
module tb_bitrev_reorder_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] out_data;
    logic       out_last;
    logic       busy;
    logic       frame_done;

    bitrev_reorder_ctrl #(.W(9), .D(8), .LOG_D(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] base;
        bit         stall;
        bit         junk;
        logic [8:0] exp [8];
    } vec_t;

    typedef struct {
        logic [8:0] d;
        logic       l;
    } sb_t;

    vec_t vecs [7];
    sb_t  sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Output monitor: scoreboard compare, stall stability, frame_done pulse.
    bit         fd_pend    = 0;
    bit         stall_prev = 0;
    logic [8:0] stall_d;
    logic       stall_l;

    always @(negedge clk) begin
        if (rst) begin
            fd_pend    = 0;
            stall_prev = 0;
        end else begin
            chk("frame_done", 32'(frame_done), 32'(fd_pend));
            fd_pend = 0;
            if (stall_prev && out_valid) begin
                chk("stall_hold_data", 32'(out_data), 32'(stall_d));
                chk("stall_hold_last", 32'(out_last), 32'(stall_l));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'(out_data), 32'h0);
                    n_fail++;
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_last", 32'(out_last), 32'(e.l));
                    if (e.l) fd_pend = 1;
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_d    = out_data;
            stall_l    = out_last;
        end
    end

    task automatic load_frame(input int vi);
        for (int k = 0; k < 8; k++) begin
            sb_t e;
            e.d = vecs[vi].exp[k];
            e.l = (k == 7);
            sb.push_back(e);
        end
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = vecs[vi].base + 9'(k);
            chk("load_in_ready", 32'(in_ready), 32'h1);
            chk("load_out_valid", 32'(out_valid), 32'h0);
            chk("load_busy", 32'(busy), (k != 0) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end
        in_valid = vecs[vi].junk;
        in_data  = vecs[vi].junk ? 9'h1FF : 9'h000;
        chk("first_out_valid", 32'(out_valid), 32'h1);
        chk("drain_in_ready", 32'(in_ready), 32'h0);
        chk("drain_busy", 32'(busy), 32'h1);
    endtask

    task automatic drain_frame(input int vi);
        int cyc;
        cyc = 0;
        while (out_valid === 1'b1 && cyc < 40) begin
            out_ready = vecs[vi].stall ? ((cyc % 2) == 1) : 1'b1;
            if (vecs[vi].junk) chk("junk_in_ready", 32'(in_ready), 32'h0);
            @(posedge clk); #1;
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("drain_cycles", 32'(cyc), vecs[vi].stall ? 32'd16 : 32'd8);
        chk("in_ready_after_frame", 32'(in_ready), 32'h1);
        chk("busy_after_frame", 32'(busy), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{base: 9'h010, stall: 0, junk: 0, exp: '{9'h010, 9'h014, 9'h012, 9'h016, 9'h011, 9'h015, 9'h013, 9'h017}};
        vecs[1] = '{base: 9'h010, stall: 1, junk: 0, exp: '{9'h010, 9'h014, 9'h012, 9'h016, 9'h011, 9'h015, 9'h013, 9'h017}};
        vecs[2] = '{base: 9'h0A0, stall: 0, junk: 1, exp: '{9'h0A0, 9'h0A4, 9'h0A2, 9'h0A6, 9'h0A1, 9'h0A5, 9'h0A3, 9'h0A7}};
        vecs[3] = '{base: 9'h0C8, stall: 0, junk: 0, exp: '{9'h0C8, 9'h0CC, 9'h0CA, 9'h0CE, 9'h0C9, 9'h0CD, 9'h0CB, 9'h0CF}};
        vecs[4] = '{base: 9'h1F8, stall: 1, junk: 1, exp: '{9'h1F8, 9'h1FC, 9'h1FA, 9'h1FE, 9'h1F9, 9'h1FD, 9'h1FB, 9'h1FF}};
        vecs[5] = '{base: 9'h040, stall: 0, junk: 0, exp: '{9'h040, 9'h044, 9'h042, 9'h046, 9'h041, 9'h045, 9'h043, 9'h047}};
        vecs[6] = '{base: 9'h100, stall: 0, junk: 0, exp: '{9'h100, 9'h104, 9'h102, 9'h106, 9'h101, 9'h105, 9'h103, 9'h107}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 9'h000;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_last", 32'(out_last), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_frame_done", 32'(frame_done), 32'h0);
        rst = 1'b0;

        // Back-to-back frames from the table.
        for (int v = 0; v < 5; v++) begin
            load_frame(v);
            drain_frame(v);
        end

        // Reset after three outputs of a frame.
        load_frame(5);
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b0;
        sb.delete();
        chk("midrst_in_ready", 32'(in_ready), 32'h1);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        chk("midrst_out_last", 32'(out_last), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_frame_done", 32'(frame_done), 32'h0);

        load_frame(6);
        drain_frame(6);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
